// File: rtl/flt_pkg.sv
// rtl/flt_pkg.sv - shared state type and default frame geometry for the filter sequencer
// Contents: state enum, default H_PIXELS/V_LINES/BURST_BYTES/MAX_OUTST,
// derived LINE_BYTES/LINE_BURSTS, and a helper for bursts per line.
package flt_pkg;

  localparam int H_PIXELS_DEF    = 640;
  localparam int V_LINES_DEF     = 480;
  localparam int BURST_BYTES_DEF = 256;
  localparam int MAX_OUTST_DEF   = 16;
  localparam int BYTES_PER_PIXEL = 4;

  localparam int LINE_BYTES  = H_PIXELS_DEF * BYTES_PER_PIXEL;
  localparam int LINE_BURSTS = LINE_BYTES / BURST_BYTES_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_DRAIN = 2'd3
  } flt_state_e;

  function automatic int calc_line_bursts(input int h_pixels, input int burst_bytes);
    return (h_pixels * BYTES_PER_PIXEL) / burst_bytes;
  endfunction

endpackage

// File: rtl/flt_seqctrl_if.sv
// rtl/flt_seqctrl_if.sv - DMA burst command bundle between the sequencer and the memory port
// Signals: RD_REQ/RD_ADDR/RD_ACK read command handshake,
// WR_REQ/WR_ADDR/WR_ACK write command handshake, WR_DONE write burst completion pulse.
// Modports: master (sequencer side), slave (memory side).
interface flt_seqctrl_if;

  logic        RD_REQ;
  logic [31:0] RD_ADDR;
  logic        RD_ACK;
  logic        WR_REQ;
  logic [31:0] WR_ADDR;
  logic        WR_ACK;
  logic        WR_DONE;

  modport master (
    output RD_REQ, RD_ADDR, WR_REQ, WR_ADDR,
    input  RD_ACK, WR_ACK, WR_DONE
  );

  modport slave (
    input  RD_REQ, RD_ADDR, WR_REQ, WR_ADDR,
    output RD_ACK, WR_ACK, WR_DONE
  );

endinterface

// File: rtl/flt_addrgen.sv
// rtl/flt_addrgen.sv - base latch plus line/burst address accumulators for one DMA direction
// Ports: CLK, ARST (sync, active-high); clr (soft abort), load + base (frame start),
// adv_burst (next burst in line), adv_line (jump to start of next line); addr (registered).
module flt_addrgen
  import flt_pkg::*;
#(
  parameter int LINE_BYTES_P  = LINE_BYTES,
  parameter int BURST_BYTES_P = BURST_BYTES_DEF
) (
  input  logic        CLK,
  input  logic        ARST,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] base,
  input  logic        adv_burst,
  input  logic        adv_line,
  output logic [31:0] addr
);

  logic [31:0] line_base_q, line_base_d;
  logic [31:0] addr_q, addr_d;

  // line_base_q tracks the start of the current line so the next line start
  // never depends on the burst size dividing the line length evenly.
  always_comb begin
    line_base_d = line_base_q;
    addr_d      = addr_q;
    if (clr) begin
      line_base_d = '0;
      addr_d      = '0;
    end else if (load) begin
      line_base_d = base;
      addr_d      = base;
    end else if (adv_line) begin
      line_base_d = line_base_q + 32'(LINE_BYTES_P);
      addr_d      = line_base_q + 32'(LINE_BYTES_P);
    end else if (adv_burst) begin
      addr_d = addr_q + 32'(BURST_BYTES_P);
    end
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      line_base_q <= '0;
      addr_q      <= '0;
    end else begin
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/flt_seqctrl.sv
// rtl/flt_seqctrl.sv - frame sequencer: per line, read bursts then write bursts, then drain
// Ports: CLK, ARST (sync, active-high); FLTRG_START start pulse, FLTRG_RSTS soft abort,
// FLTRG_VRAMSRC/FLTRG_VRAMFRM source/destination bases; dma (flt_seqctrl_if.master);
// FLTVC_BUSY frame in progress, FLTVC_INT frame-complete pulse. All outputs registered.
module flt_seqctrl
  import flt_pkg::*;
#(
  parameter int H_PIXELS    = H_PIXELS_DEF,
  parameter int V_LINES     = V_LINES_DEF,
  parameter int BURST_BYTES = BURST_BYTES_DEF,
  parameter int MAX_OUTST   = MAX_OUTST_DEF
) (
  input  logic                CLK,
  input  logic                ARST,
  input  logic                FLTRG_START,
  input  logic                FLTRG_RSTS,
  input  logic [31:0]         FLTRG_VRAMSRC,
  input  logic [31:0]         FLTRG_VRAMFRM,
  flt_seqctrl_if.master       dma,
  output logic                FLTVC_BUSY,
  output logic                FLTVC_INT
);

  localparam int L_BYTES  = H_PIXELS * BYTES_PER_PIXEL;
  localparam int L_BURSTS = calc_line_bursts(H_PIXELS, BURST_BYTES);
  localparam int BW = $clog2(L_BURSTS + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [BW-1:0] LAST_BURST = BW'(L_BURSTS - 1);
  localparam logic [LW-1:0] LAST_LINE  = LW'(V_LINES - 1);
  localparam logic [OW-1:0] OUTST_MAX  = OW'(MAX_OUTST);

  flt_state_e    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [LW-1:0] line_q, line_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          busy_q, busy_d;
  logic          int_q, int_d;

  logic          rd_hs, wr_hs, done_ok;
  logic          ag_load;
  logic          rd_adv_burst, rd_adv_line;
  logic          wr_adv_burst, wr_adv_line;
  logic [31:0]   rd_addr, wr_addr;

  assign rd_hs   = rd_req_q & dma.RD_ACK;
  assign wr_hs   = wr_req_q & dma.WR_ACK;
  // A completion with nothing outstanding is stray and must not underflow.
  assign done_ok = dma.WR_DONE && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (FLTRG_RSTS) begin
      outst_d = '0;
    end else begin
      case ({wr_hs, done_ok})
        2'b10:   outst_d = outst_q + OW'(1);
        2'b01:   outst_d = outst_q - OW'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      state_q  <= ST_IDLE;
      burst_q  <= '0;
      line_q   <= '0;
      outst_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      line_q   <= line_d;
      outst_q  <= outst_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      busy_q   <= busy_d;
      int_q    <= int_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    line_d       = line_q;
    ag_load      = 1'b0;
    rd_adv_burst = 1'b0;
    rd_adv_line  = 1'b0;
    wr_adv_burst = 1'b0;
    wr_adv_line  = 1'b0;
    if (FLTRG_RSTS) begin
      state_d = ST_IDLE;
      burst_d = '0;
      line_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (FLTRG_START) begin
            state_d = ST_RD;
            burst_d = '0;
            line_d  = '0;
            ag_load = 1'b1;
          end
        end
        ST_RD: begin
          if (rd_hs) begin
            if (burst_q == LAST_BURST) begin
              state_d     = ST_WR;
              burst_d     = '0;
              rd_adv_line = 1'b1;
            end else begin
              burst_d      = burst_q + BW'(1);
              rd_adv_burst = 1'b1;
            end
          end
        end
        ST_WR: begin
          if (wr_hs) begin
            if (burst_q == LAST_BURST) begin
              burst_d     = '0;
              wr_adv_line = 1'b1;
              if (line_q == LAST_LINE) begin
                state_d = ST_DRAIN;
              end else begin
                state_d = ST_RD;
                line_d  = line_q + LW'(1);
              end
            end else begin
              burst_d      = burst_q + BW'(1);
              wr_adv_burst = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Looking at the next count lets INT follow the final completion by one cycle.
          if (outst_d == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    rd_req_d = (state_d == ST_RD);
    wr_req_d = (state_d == ST_WR) && (outst_d < OUTST_MAX);
    busy_d   = (state_d != ST_IDLE);
    int_d    = (state_q == ST_DRAIN) && (state_d == ST_IDLE) && !FLTRG_RSTS;
  end

  flt_addrgen #(
    .LINE_BYTES_P  (L_BYTES),
    .BURST_BYTES_P (BURST_BYTES)
  ) u_rd_ag (
    .CLK       (CLK),
    .ARST      (ARST),
    .clr       (FLTRG_RSTS),
    .load      (ag_load),
    .base      (FLTRG_VRAMSRC),
    .adv_burst (rd_adv_burst),
    .adv_line  (rd_adv_line),
    .addr      (rd_addr)
  );

  flt_addrgen #(
    .LINE_BYTES_P  (L_BYTES),
    .BURST_BYTES_P (BURST_BYTES)
  ) u_wr_ag (
    .CLK       (CLK),
    .ARST      (ARST),
    .clr       (FLTRG_RSTS),
    .load      (ag_load),
    .base      (FLTRG_VRAMFRM),
    .adv_burst (wr_adv_burst),
    .adv_line  (wr_adv_line),
    .addr      (wr_addr)
  );

  assign dma.RD_REQ  = rd_req_q;
  assign dma.RD_ADDR = rd_addr;
  assign dma.WR_REQ  = wr_req_q;
  assign dma.WR_ADDR = wr_addr;
  assign FLTVC_BUSY  = busy_q;
  assign FLTVC_INT   = int_q;

endmodule

// File: doc/flt_seqctrl.md
FLT_SEQCTRL -- requirements
Module: flt_seqctrl

Interface
REQ-001 Parameter H_PIXELS, 640, pixels per line.
REQ-002 Parameter V_LINES, 480, lines per frame.
REQ-003 Parameter BURST_BYTES, 256, bytes per DMA burst command (4 bytes/pixel, 10 bursts per line at defaults).
REQ-004 Parameter MAX_OUTST, 16, maximum write bursts issued but not yet completed.
REQ-005 CLK  in  1  clock; reset ARST, synchronous, active-high, clock CLK.
REQ-006 ARST  in  1  synchronous active-high reset.
REQ-007 FLTRG_START  in  1  one-cycle frame start pulse from register block.
REQ-008 FLTRG_RSTS  in  1  soft reset / abort, level, may last several cycles.
REQ-009 FLTRG_VRAMSRC  in  32  source frame base byte address.
REQ-010 FLTRG_VRAMFRM  in  32  destination frame base byte address.
REQ-011 RD_REQ / RD_ADDR  out  1 / 32  read burst command valid / byte address.
REQ-012 RD_ACK  in  1  read command accepted.
REQ-013 WR_REQ / WR_ADDR  out  1 / 32  write burst command valid / byte address.
REQ-014 WR_ACK  in  1  write command accepted.
REQ-015 WR_DONE  in  1  one-cycle pulse per completed write burst.
REQ-016 FLTVC_BUSY  out  1  frame in progress.
REQ-017 FLTVC_INT  out  1  one-cycle frame-complete pulse.

Function
REQ-018 States SHALL be IDLE, RD, WR, DRAIN; all outputs registered.
REQ-019 IDLE + FLTRG_START SHALL latch both base addresses, clear line/burst counters, enter RD next cycle; FLTVC_BUSY SHALL be 1 from the cycle after START until return to IDLE.
REQ-020 RD SHALL hold RD_REQ=1 with stable RD_ADDR until RD_ACK; on each ACK burst index increments, RD_ADDR advances by BURST_BYTES; after LINE_BURSTS (H_PIXELS*4/BURST_BYTES) ACKs, enter WR with burst index 0.
REQ-021 WR SHALL issue LINE_BURSTS write commands with the same handshake; WR_REQ SHALL be 0 while outstanding count == MAX_OUTST.
REQ-022 After the last WR_ACK of a line: if line < V_LINES-1, increment line, enter RD; else enter DRAIN.
REQ-023 Address = latched base + line*H_PIXELS*4 + burst*BURST_BYTES, computed by running accumulators (no multiplier), modulo 2^32 wrap-around.
REQ-024 Outstanding count: +1 on WR_ACK, -1 on WR_DONE, unchanged when both in one cycle; WR_DONE at count 0 ignored.
REQ-025 DRAIN SHALL wait for outstanding count 0, then pulse FLTVC_INT one cycle and return to IDLE in the same transition.
REQ-026 FLTRG_START while not IDLE SHALL be ignored; base address changes mid-frame SHALL have no effect.
REQ-027 FLTRG_RSTS SHALL, from the next cycle, force IDLE, drop RD_REQ/WR_REQ, clear all counters, suppress FLTVC_INT; RSTS wins over a simultaneous START.

Reset
REQ-028 ARST SHALL set state IDLE, all counters 0, RD_REQ=0, WR_REQ=0, RD_ADDR=0, WR_ADDR=0, FLTVC_BUSY=0, FLTVC_INT=0.

Structure
REQ-029 Package flt_pkg SHALL hold the state enum, H_PIXELS/V_LINES/BURST_BYTES defaults and derived LINE_BYTES/LINE_BURSTS constants.
REQ-030 Sub-module flt_addrgen (base latch, line/burst accumulators, one instance each for read and write) is natural; FSM and outstanding counter stay in flt_seqctrl.

Verification
REQ-031 V_LINES=2, SRC=0x1000_0000, FRM=0x2000_0000, ACK same cycle as REQ -> RD_ADDR 0x1000_0000..0x1000_0900, then WR 0x2000_0000..0x2000_0900, then line 1 at 0x1000_0A00; INT one cycle after final WR_DONE.
REQ-032 Withhold WR_DONE -> after 16 WR_ACKs WR_REQ drops; one WR_DONE -> WR_REQ reasserts next cycle.
REQ-033 WR_ACK and WR_DONE same cycle at count 5 -> count stays 5; WR_DONE at count 0 -> count stays 0.
REQ-034 START mid-frame with new SRC=0x3000_0000 -> addresses continue from original base, no restart.
REQ-035 RSTS during RD with RD_REQ high -> RD_REQ=0, BUSY=0 next cycle, no INT; following START runs a full frame from line 0.
REQ-036 SRC=0xFFFF_FF00 -> second RD_ADDR wraps to 0x0000_0000.
